// File: rtl/io_arbiter_rr_pkg.sv
// io_arbiter_rr_pkg: shared types, channel indices and address map for the IO arbiter
package io_arbiter_rr_pkg;
  typedef logic [1:0] io_state_t;
  localparam io_state_t IO_IDLE  = 2'd0;
  localparam io_state_t IO_ISSUE = 2'd1;
  localparam io_state_t IO_DONE  = 2'd2;
  localparam logic IO_IN  = 1'b1;
  localparam logic IO_OUT = 1'b0;
  localparam int VGA_I = 0;
  localparam int PS2_I = 1;
  localparam int IO_WORD_SIZE = 64;
  localparam int IO_ADDR_SIZE = 20;
  localparam int IO_CH_COUNT  = 2;
  localparam int IO_TIMEOUT   = 255;
  localparam logic [IO_ADDR_SIZE-1:0] VGA_MEM_OFFSET = 20'h00081;
  localparam logic [IO_ADDR_SIZE-1:0] PS2_MEM_OFFSET = 20'h00000;
  localparam logic [IO_CH_COUNT*IO_ADDR_SIZE-1:0] IO_CH_OFFSET = {PS2_MEM_OFFSET, VGA_MEM_OFFSET};
endpackage

// File: rtl/io_arbiter_rr_if.sv
// io_arbiter_rr_if: device-channel and memory-port bundle of the IO arbiter
interface io_arbiter_rr_if
  import io_arbiter_rr_pkg::*;
#(
  parameter int CH_COUNT  = IO_CH_COUNT,
  parameter int WORD_SIZE = IO_WORD_SIZE,
  parameter int ADDR_SIZE = IO_ADDR_SIZE
);
  logic [CH_COUNT-1:0]           ch_req;
  logic [CH_COUNT-1:0]           ch_dir;
  logic [CH_COUNT*ADDR_SIZE-1:0] ch_addr;
  logic [CH_COUNT*WORD_SIZE-1:0] ch_wdata;
  logic [CH_COUNT-1:0]           ch_gnt;
  logic [CH_COUNT-1:0]           ch_done;
  logic [CH_COUNT-1:0]           ch_err;
  logic [WORD_SIZE-1:0]          ch_rdata;
  logic                          mem_valid;
  logic                          mem_we;
  logic [ADDR_SIZE-1:0]          mem_addr;
  logic [WORD_SIZE-1:0]          mem_wdata;
  logic                          mem_ready;
  logic [WORD_SIZE-1:0]          mem_rdata;
  modport master (
    input  ch_req, ch_dir, ch_addr, ch_wdata, mem_ready, mem_rdata,
    output ch_gnt, ch_done, ch_err, ch_rdata, mem_valid, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output ch_req, ch_dir, ch_addr, ch_wdata, mem_ready, mem_rdata,
    input  ch_gnt, ch_done, ch_err, ch_rdata, mem_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/io_arbiter_rr_pick.sv
// io_arbiter_rr_pick: round-robin pick of the first request after the last grant
module io_arbiter_rr_pick #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last) + k) % N]) idx = IW'((int'(last) + k) % N);
  end
  assign any = |req;
  assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/io_arbiter_rr.sv
// io_arbiter_rr: round-robin serialiser of IO channel word transfers onto one memory port
module io_arbiter_rr
  import io_arbiter_rr_pkg::*;
#(
  parameter int WORD_SIZE = IO_WORD_SIZE,
  parameter int ADDR_SIZE = IO_ADDR_SIZE,
  parameter int CH_COUNT  = IO_CH_COUNT,
  parameter logic [CH_COUNT*ADDR_SIZE-1:0] CH_OFFSET = IO_CH_OFFSET,
  parameter int TIMEOUT   = IO_TIMEOUT
) (
  input logic clk,
  input logic rst_n,
  io_arbiter_rr_if.master bus
);
  localparam int IW = CH_COUNT > 1 ? $clog2(CH_COUNT) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  io_state_t             state_q, state_d;
  logic [IW-1:0]         last_q, last_d, idx_q, idx_d, pick_idx;
  logic [CH_COUNT-1:0]   gnt_q, gnt_d, err_q, err_d, pick_gnt;
  logic                  dir_q, dir_d, pick_any, issue, timeout;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  io_arbiter_rr_pick #(.N(CH_COUNT)) u_pick (
    .req  (bus.ch_req),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );
  assign issue   = state_q == IO_ISSUE;
  assign timeout = cnt_q == CW'(TIMEOUT - 1);
  // mem_ready is tested before timeout so a last-cycle response still completes
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = '0;
    cnt_d   = issue && !bus.mem_ready ? cnt_q + 1'b1 : '0;
    if (state_q == IO_IDLE && pick_any) begin
      state_d = IO_ISSUE;
      idx_d   = pick_idx;
      gnt_d   = pick_gnt;
      dir_d   = bus.ch_dir[pick_idx];
      addr_d  = CH_OFFSET[pick_idx*ADDR_SIZE +: ADDR_SIZE] + bus.ch_addr[pick_idx*ADDR_SIZE +: ADDR_SIZE];
      wdata_d = bus.ch_wdata[pick_idx*WORD_SIZE +: WORD_SIZE];
    end else if (issue && bus.mem_ready) begin
      state_d = IO_DONE;
      rdata_d = dir_q == IO_OUT ? bus.mem_rdata : rdata_q;
    end else if ((issue && timeout) || state_q == IO_DONE) begin
      state_d = IO_IDLE;
      gnt_d   = '0;
      last_d  = idx_q;
      err_d   = issue ? gnt_q : '0;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IO_IDLE;
      last_q  <= IW'(CH_COUNT - 1);
      idx_q   <= '0;
      gnt_q   <= '0;
      err_q   <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.ch_gnt    = gnt_q;
  assign bus.ch_done   = state_q == IO_DONE ? gnt_q : '0;
  assign bus.ch_err    = err_q;
  assign bus.ch_rdata  = rdata_q;
  assign bus.mem_valid = issue;
  assign bus.mem_we    = issue & dir_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_io_arbiter_rr.sv
// tb_io_arbiter_rr: directed and randomized transactions checked against a transaction-level model
module tb_io_arbiter_rr;
  localparam int TO = 4;
  localparam logic [19:0] OFF [2] = '{20'h00081, 20'h00000};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int last_m = 1;
  logic [63:0] rdata_m = '0;
  io_arbiter_rr_if #(.CH_COUNT(2), .WORD_SIZE(64), .ADDR_SIZE(20)) bus ();
  io_arbiter_rr #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog expired");
  end
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int model_pick(input logic [1:0] req);
    for (int k = 1; k <= 2; k++) if (req[(last_m + k) % 2]) return (last_m + k) % 2;
    return -1;
  endfunction
  task automatic scramble;
    bus.ch_req   = 2'($urandom);
    bus.ch_dir   = 2'($urandom);
    bus.ch_addr  = 40'({$urandom, $urandom});
    bus.ch_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_outs"}, {bus.ch_gnt, bus.ch_done, bus.ch_err, bus.ch_rdata, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata}, '0);
  endtask
  // One transfer starting in an idle cycle; d = cycles of mem_ready low before it rises (d >= TO times out)
  task automatic run_txn(input logic [1:0] req, input logic [1:0] dir, input logic [39:0] addr,
                         input logic [127:0] wd, input int d, input logic [63:0] rd, input int exp_addr);
    int ch;
    logic [19:0] pa;
    logic        we;
    logic [63:0] wv;
    bus.ch_req = req; bus.ch_dir = dir; bus.ch_addr = addr; bus.ch_wdata = wd;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    ch = model_pick(req);
    tick;
    if (ch < 0) begin
      chk("idle_valid", bus.mem_valid, 0);
      chk("idle_gnt", bus.ch_gnt, 0);
      return;
    end
    pa = OFF[ch] + addr[ch*20 +: 20];
    we = dir[ch];
    wv = wd[ch*64 +: 64];
    if (exp_addr >= 0) chk("addr_const", bus.mem_addr, exp_addr);
    for (int k = 0; k < TO; k++) begin
      chk("issue_valid", bus.mem_valid, 1);
      chk("issue_gnt", bus.ch_gnt, 1 << ch);
      chk("issue_addr", bus.mem_addr, pa);
      chk("issue_we", bus.mem_we, we);
      chk("issue_wdata", bus.mem_wdata, wv);
      chk("issue_flags", {bus.ch_done, bus.ch_err}, 0);
      chk("issue_rdata", bus.ch_rdata, rdata_m);
      scramble;
      if (k == d) begin
        bus.mem_ready = 1'b1; bus.mem_rdata = rd;
        tick;
        bus.mem_ready = 1'b0; bus.mem_rdata = 64'($urandom);
        if (!we) rdata_m = rd;
        last_m = ch;
        chk("done_pulse", bus.ch_done, 1 << ch);
        chk("done_gnt", bus.ch_gnt, 1 << ch);
        chk("done_valid", bus.mem_valid, 0);
        chk("done_err", bus.ch_err, 0);
        chk("done_rdata", bus.ch_rdata, rdata_m);
        tick;
        chk("after_done", {bus.ch_done, bus.ch_gnt, bus.mem_valid}, 0);
        chk("after_rdata", bus.ch_rdata, rdata_m);
        return;
      end
      tick;
    end
    last_m = ch;
    chk("err_pulse", bus.ch_err, 1 << ch);
    chk("err_quiet", {bus.ch_done, bus.ch_gnt, bus.mem_valid}, 0);
  endtask
  initial begin
    bus.ch_req = '0; bus.ch_dir = '0; bus.ch_addr = '0; bus.ch_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    tick;
    tick;
    chk_quiet("reset");
    rst_n = 1'b1;
    run_txn(2'b01, 2'b01, {20'h0, 20'h5}, {64'h0, 64'hDEAD}, 0, 64'h0, 'h86);
    run_txn(2'b10, 2'b00, 40'h0, 128'h0, 0, 64'h41, 'h0);
    chk("read_rdata", bus.ch_rdata, 64'h41);
    for (int i = 0; i < 4; i++)
      run_txn(2'b11, 2'($urandom), 40'({$urandom, $urandom}), {$urandom, $urandom, $urandom, $urandom}, 1, 64'($urandom), -1);
    run_txn(2'b01, 2'b01, 40'h12345, 128'hABC, TO, 64'h0, -1);
    run_txn(2'b10, 2'b00, 40'h0, 128'h0, 0, 64'h77, 'h0);
    run_txn(2'b01, 2'b00, 40'h00010, 128'h0, TO - 1, 64'h99, 'h91);
    run_txn(2'b01, 2'b00, {20'h0, 20'hFFFFF}, 128'h0, 2, 64'h5A5A, 'h80);
    bus.ch_req = 2'b01; bus.ch_dir = 2'b01; bus.ch_addr = 40'h3; bus.ch_wdata = 128'h1234;
    tick;
    chk("pre_reset_valid", bus.mem_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk_quiet("mid_reset");
    tick;
    rst_n = 1'b1;
    last_m = 1;
    rdata_m = '0;
    run_txn(2'b11, 2'b00, 40'h0, 128'h0, 0, 64'hC0FFEE, 'h81);
    for (int i = 0; i < 60; i++)
      run_txn(2'($urandom), 2'($urandom), 40'({$urandom, $urandom}), {$urandom, $urandom, $urandom, $urandom},
              int'($urandom_range(0, TO + 1)), {$urandom, $urandom}, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
